// File: rtl/convergence_monitor.sv
// Serial convergence check for the power-iteration loop. It accumulates the norm of one
// (vector, next_vector) difference per check and raises sticky converged/timeout flags.
//   state    | meaning
//   S_IDLE   | ready for the next vector pair
//   S_ACCUM  | folding one element difference into acc per cycle
//   S_DECIDE | compare acc with tol, update counters and flags
//   S_HALT   | converged or timed out, wait for clear
module convergence_monitor #(
  parameter int SIZE_N    = 8,
  parameter int WIDTH     = 16,
  parameter int MAX_ITER  = 100,
  parameter int NORM_MODE = 0,
  parameter int CONSEC    = 1,
  localparam int ACC_W    = 2*(WIDTH+1)+$clog2(SIZE_N),
  localparam int CNT_W    = $clog2(MAX_ITER+1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SIZE_N*WIDTH-1:0] vector,
  input  logic [SIZE_N*WIDTH-1:0] next_vector,
  input  logic [ACC_W-1:0]        tol,
  output logic                    result_valid,
  output logic                    below_tol,
  output logic                    converged,
  output logic                    timeout,
  output logic [ACC_W-1:0]        norm_out,
  output logic [CNT_W-1:0]        iter_count
);

  localparam int IDX_W = $clog2(SIZE_N);
  localparam int SQ_W  = 2*(WIDTH+1);
  localparam int CON_W = $clog2(CONSEC+1);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DECIDE, S_HALT} state_t;

  state_t                  state_q, state_d;
  logic [SIZE_N*WIDTH-1:0] vec_q, vec_d, nvec_q, nvec_d;
  logic [ACC_W-1:0]        tol_q, tol_d, acc_q, acc_d, norm_q, norm_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CON_W-1:0]        consec_q, consec_d;
  logic [CNT_W-1:0]        iter_q, iter_d;
  logic                    below_q, below_d, conv_q, conv_d, tout_q, tout_d, rv_q, rv_d;

  // Stored vectors shift down one element per ACCUM cycle, so element 0 is always current.
  logic signed [WIDTH:0]   diff;
  logic [WIDTH:0]          diff_u, mag;
  logic signed [SQ_W-1:0]  diff_x, sq;
  logic [ACC_W-1:0]        sq_ext, mag_ext, acc_step;

  assign diff    = $signed({nvec_q[WIDTH-1], nvec_q[WIDTH-1:0]})
                 - $signed({vec_q[WIDTH-1], vec_q[WIDTH-1:0]});
  assign diff_u  = diff;
  assign mag     = diff_u[WIDTH] ? (~diff_u + (WIDTH+1)'(1)) : diff_u;
  assign diff_x  = SQ_W'(diff);
  assign sq      = diff_x * diff_x;
  assign sq_ext  = ACC_W'($unsigned(sq));
  assign mag_ext = ACC_W'(mag);

  always_comb begin
    acc_step = acc_q;
    if (NORM_MODE == 0) acc_step = acc_q + sq_ext;
    else if (mag_ext > acc_q) acc_step = mag_ext;
  end

  logic                  below_now, conv_now, tout_now;
  logic [CON_W:0]        consec_inc;
  logic [CNT_W-1:0]      iter_inc;

  assign below_now  = (acc_q <= tol_q);
  assign consec_inc = {1'b0, consec_q} + (CON_W+1)'(1);
  assign conv_now   = below_now && (consec_inc >= (CON_W+1)'(CONSEC));
  assign iter_inc   = iter_q + CNT_W'(1);
  // Convergence wins when it lands on the last allowed check.
  assign tout_now   = !conv_now && (iter_inc == CNT_W'(MAX_ITER));

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    nvec_d   = nvec_q;
    tol_d    = tol_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    consec_d = consec_q;
    norm_d   = norm_q;
    below_d  = below_q;
    conv_d   = conv_q;
    tout_d   = tout_q;
    iter_d   = iter_q;
    rv_d     = 1'b0;
    if (clear) begin
      state_d  = S_IDLE;
      acc_d    = '0;
      idx_d    = '0;
      consec_d = '0;
      norm_d   = '0;
      below_d  = 1'b0;
      conv_d   = 1'b0;
      tout_d   = 1'b0;
      iter_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            vec_d   = vector;
            nvec_d  = next_vector;
            tol_d   = tol;
            acc_d   = '0;
            idx_d   = '0;
            state_d = S_ACCUM;
          end
        end
        S_ACCUM: begin
          acc_d  = acc_step;
          vec_d  = vec_q >> WIDTH;
          nvec_d = nvec_q >> WIDTH;
          idx_d  = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(SIZE_N-1)) state_d = S_DECIDE;
        end
        S_DECIDE: begin
          norm_d   = acc_q;
          below_d  = below_now;
          iter_d   = iter_inc;
          consec_d = below_now ? consec_inc[CON_W-1:0] : '0;
          conv_d   = conv_now;
          tout_d   = tout_now;
          rv_d     = 1'b1;
          state_d  = (conv_now || tout_now) ? S_HALT : S_IDLE;
        end
        S_HALT:  state_d = S_HALT;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      vec_q    <= '0;
      nvec_q   <= '0;
      tol_q    <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      consec_q <= '0;
      norm_q   <= '0;
      below_q  <= 1'b0;
      conv_q   <= 1'b0;
      tout_q   <= 1'b0;
      iter_q   <= '0;
      rv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      nvec_q   <= nvec_d;
      tol_q    <= tol_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      consec_q <= consec_d;
      norm_q   <= norm_d;
      below_q  <= below_d;
      conv_q   <= conv_d;
      tout_q   <= tout_d;
      iter_q   <= iter_d;
      rv_q     <= rv_d;
    end
  end

  assign in_ready     = (state_q == S_IDLE);
  assign result_valid = rv_q;
  assign below_tol    = below_q;
  assign converged    = conv_q;
  assign timeout      = tout_q;
  assign norm_out     = norm_q;
  assign iter_count   = iter_q;

endmodule
